// File: rtl/alu_seq_divider.sv
// Multi-cycle unsigned restoring divider for the ALU datapath.
// One trial subtract with borrow detect per clock, WIDTH steps per division,
// start/done handshake toward the ALU control FSM.
module alu_seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] dvsr_q;

  logic [WIDTH:0]   rs;
  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  assign busy = (state == CALC);
  assign done = (state == DONE);

  // One restoring step: shift in the next dividend bit, trial subtract,
  // keep the difference only when the WIDTH+1-bit subtract did not borrow.
  always_comb begin
    rs     = {r_q, q_q[WIDTH-1]};
    t      = rs - {1'b0, dvsr_q};
    r_next = rs[WIDTH-1:0];
    q_next = {q_q[WIDTH-2:0], 1'b0};
    if (!t[WIDTH]) begin
      r_next = t[WIDTH-1:0];
      q_next = {q_q[WIDTH-2:0], 1'b1};
    end
  end

  // Control FSM, working registers and held results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      r_q         <= '0;
      q_q         <= '0;
      dvsr_q      <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              dvsr_q      <= divisor;
              r_q         <= '0;
              q_q         <= dividend;
              cnt         <= '0;
              div_by_zero <= 1'b0;
              state       <= CALC;
            end else begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end
          end
        end
        CALC: begin
          r_q <= r_next;
          q_q <= q_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            quotient  <= q_next;
            remainder <= r_next;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_divider.sv
// Directed bench for alu_seq_divider (WIDTH=8): table of division vectors plus
// hand-written reset, ignored-start, stability and back-to-back sequences.
module tb_alu_seq_divider;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int nvec;
  int nerr;

  alu_seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Wait one rising edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge and follow the division to done.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz);
    int lat;
    int bcnt;
    int both;
    lat  = 0;
    bcnt = 0;
    both = 0;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    if (busy) bcnt++;
    if (busy && done) both++;
    while (!done && lat < 40) begin
      tick();
      lat++;
      if (busy) bcnt++;
      if (busy && done) both++;
    end
    check($sformatf("latency %0d/%0d", a, b), lat, edz ? 1 : W + 1);
    check($sformatf("busy_cycles %0d/%0d", a, b), bcnt, edz ? 0 : W);
    check($sformatf("quotient %0d/%0d", a, b), int'(quotient), int'(eq));
    check($sformatf("remainder %0d/%0d", a, b), int'(remainder), int'(er));
    check($sformatf("div_by_zero %0d/%0d", a, b), int'(div_by_zero), int'(edz));
    check($sformatf("busy_and_done %0d/%0d", a, b), both, 0);
    tick();
    check($sformatf("done_one_cycle %0d/%0d", a, b), int'(done), 0);
  endtask

  initial begin
    vec_t vt[13];
    int   cnt_done;
    int   drift;
    int   last_done;
    int   cyc;
    int   both;
    logic [W-1:0] ra[13];
    logic [W-1:0] rb[13];

    nvec = 0;
    nerr = 0;

    vt[0]  = '{a: 8'd200, b: 8'd7,   q: 8'd28,  r: 8'd4,  dz: 1'b0};
    vt[1]  = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,  dz: 1'b0};
    vt[2]  = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,  dz: 1'b0};
    vt[3]  = '{a: 8'd0,   b: 8'd3,   q: 8'd0,   r: 8'd0,  dz: 1'b0};
    vt[4]  = '{a: 8'd128, b: 8'd128, q: 8'd1,   r: 8'd0,  dz: 1'b0};
    vt[5]  = '{a: 8'd42,  b: 8'd0,   q: 8'd255, r: 8'd42, dz: 1'b1};
    vt[6]  = '{a: 8'd10,  b: 8'd3,   q: 8'd3,   r: 8'd1,  dz: 1'b0};
    vt[7]  = '{a: 8'd1,   b: 8'd255, q: 8'd0,   r: 8'd1,  dz: 1'b0};
    vt[8]  = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,  dz: 1'b0};
    vt[9]  = '{a: 8'd254, b: 8'd16,  q: 8'd15,  r: 8'd14, dz: 1'b0};
    vt[10] = '{a: 8'd99,  b: 8'd2,   q: 8'd49,  r: 8'd1,  dz: 1'b0};
    vt[11] = '{a: 8'd0,   b: 8'd0,   q: 8'd255, r: 8'd0,  dz: 1'b1};
    vt[12] = '{a: 8'd255, b: 8'd128, q: 8'd1,   r: 8'd127, dz: 1'b0};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) tick();
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_quotient", int'(quotient), 0);
    check("reset_remainder", int'(remainder), 0);
    check("reset_dz", int'(div_by_zero), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vt[i]) do_div(vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].dz);

    // Reset in the middle of CALC: no done, all outputs cleared.
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd9;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("midreset_busy_before", int'(busy), 1);
    repeat (4) tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset_busy", int'(busy), 0);
    check("midreset_quotient", int'(quotient), 0);
    check("midreset_remainder", int'(remainder), 0);
    check("midreset_dz", int'(div_by_zero), 0);
    cnt_done = 0;
    repeat (12) begin
      tick();
      if (done || busy) cnt_done++;
    end
    check("midreset_no_activity", cnt_done, 0);
    do_div(8'd100, 8'd9, 8'd11, 8'd1, 1'b0);

    // Restart attempt and operand changes while busy are ignored.
    @(negedge clk);
    dividend = 8'd77;
    divisor  = 8'd5;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    dividend = 8'd99;
    divisor  = 8'd2;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    check("ignored_start_done", int'(done), 1);
    check("ignored_start_quotient", int'(quotient), 15);
    check("ignored_start_remainder", int'(remainder), 2);
    drift    = 0;
    cnt_done = 0;
    repeat (20) begin
      tick();
      if (quotient != 8'd15 || remainder != 8'd2 || div_by_zero) drift++;
      if (done || busy) cnt_done++;
    end
    check("hold_results_stable", drift, 0);
    check("hold_no_activity", cnt_done, 0);

    // Back-to-back with start held high: each done checked against a model,
    // spacing between dones must be WIDTH+2 cycles.
    foreach (ra[i]) begin
      ra[i] = W'($urandom_range(0, 255));
      rb[i] = W'($urandom_range(1, 255));
    end
    rb[3] = 8'd1;
    ra[5] = 8'd255;
    @(negedge clk);
    dividend  = ra[0];
    divisor   = rb[0];
    start     = 1'b1;
    cyc       = 0;
    last_done = 0;
    both      = 0;
    for (int i = 0; i < 13; i++) begin
      int guard;
      guard = 0;
      do begin
        tick();
        cyc++;
        guard++;
        if (busy && done) both++;
      end while (!done && guard < 40);
      check($sformatf("b2b_done_%0d", i), int'(done), 1);
      check($sformatf("b2b_quotient_%0d", i), int'(quotient), int'(ra[i] / rb[i]));
      check($sformatf("b2b_remainder_%0d", i), int'(remainder), int'(ra[i] % rb[i]));
      check($sformatf("b2b_dz_%0d", i), int'(div_by_zero), 0);
      if (i > 0) check($sformatf("b2b_spacing_%0d", i), cyc - last_done, W + 2);
      last_done = cyc;
      if (i < 12) begin
        dividend = ra[i+1];
        divisor  = rb[i+1];
      end
    end
    start = 1'b0;
    check("b2b_busy_and_done", both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
